// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I-subset control unit: sequences fetch/decode/execute/memory/writeback,
// with memory wait-state timeout, illegal-opcode trap and a retired-instruction counter.
module mc_ctrl_fsm #(
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                br_taken,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_b_sel,
  output logic [1:0]          wb_sel,
  output logic [1:0]          pc_src,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_req,
  output logic                mem_we,
  output logic                busy,
  output logic                trap,
  output logic [CNT_W-1:0]    instr_cnt
);

  localparam int unsigned WaitW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StFetch   = 4'd1;
  localparam logic [3:0] StDecode  = 4'd2;
  localparam logic [3:0] StExecR   = 4'd3;
  localparam logic [3:0] StExecI   = 4'd4;
  localparam logic [3:0] StWbAlu   = 4'd5;
  localparam logic [3:0] StMemAddr = 4'd6;
  localparam logic [3:0] StMemRd   = 4'd7;
  localparam logic [3:0] StMemWr   = 4'd8;
  localparam logic [3:0] StWbMem   = 4'd9;
  localparam logic [3:0] StBranch  = 4'd10;
  localparam logic [3:0] StJal     = 4'd11;
  localparam logic [3:0] StLui     = 4'd12;
  localparam logic [3:0] StTrap    = 4'd13;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  logic [3:0]       state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             retire;
  logic             in_mem_state;
  logic             wait_expired;
  logic [3:0]       alu_r, alu_i;
  logic             unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  assign alu_r = {funct7[5], funct3};
  // Only shifts-right (funct3 101) carry the arithmetic bit for immediate ops.
  assign alu_i = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};

  assign in_mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign wait_expired = (WAIT_MAX != 0) && (wait_q == WaitW'(WAIT_MAX));

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    instr_cnt_d = instr_cnt_q;
    retire      = 1'b0;

    // Memory states leave only on ready or timeout, so the counter is zero on every entry.
    if (in_mem_state && !mem_ready) begin
      if (wait_expired) begin
        state_d = StTrap;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end

    case (state_q)
      StIdle:    if (en) state_d = StFetch;
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpcR:              state_d = StExecR;
          OpcI:              state_d = StExecI;
          OpcLoad, OpcStore: state_d = StMemAddr;
          OpcBranch:         state_d = StBranch;
          OpcJal:            state_d = StJal;
          OpcLui:            state_d = StLui;
          default:           state_d = StTrap;
        endcase
      end
      StExecR, StExecI: state_d = StWbAlu;
      StMemAddr: state_d = opcode[5] ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready) state_d = StWbMem;
      StMemWr:   if (mem_ready) retire = 1'b1;
      StWbAlu, StWbMem, StBranch, StJal, StLui: retire = 1'b1;
      StTrap:    state_d = StTrap;
      default:   state_d = StIdle;
    endcase

    if (retire) begin
      instr_cnt_d = instr_cnt_q + 1'b1;
      state_d     = en ? StFetch : StIdle;
    end
  end

  always_comb begin
    alu_op    = '0;
    alu_b_sel = 1'b0;
    wb_sel    = 2'b00;
    pc_src    = 2'b00;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    trap      = 1'b0;
    busy      = (state_q != StIdle) && (state_q != StTrap);

    case (state_q)
      StFetch: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      StExecR: alu_op = ALU_OP_W'(alu_r);
      StExecI: begin
        alu_op    = ALU_OP_W'(alu_i);
        alu_b_sel = 1'b1;
      end
      StWbAlu:   reg_write = 1'b1;
      StMemAddr: alu_b_sel = 1'b1;
      StMemRd:   mem_req = 1'b1;
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      StWbMem: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
      end
      StBranch: begin
        alu_op   = ALU_OP_W'(4'b1000);
        pc_src   = 2'b01;
        pc_write = br_taken;
      end
      StJal: begin
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        pc_src    = 2'b10;
      end
      StLui: begin
        reg_write = 1'b1;
        wb_sel    = 2'b11;
      end
      StTrap:  trap = 1'b1;
      default: ;
    endcase
  end

  assign instr_cnt = instr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomised instruction stream against a per-instruction cycle model of the control unit;
// directed cases cover wait-state boundaries, timeout trap, illegal opcodes and async reset.
module tb_mc_ctrl_fsm;

  logic       clk, rst_n, en, br_taken, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [3:0] alu_op;
  logic       alu_b_sel, pc_write, ir_write, reg_write, mem_req, mem_we, busy, trap;
  logic [1:0] wb_sel, pc_src;
  logic [3:0] instr_cnt;
  logic [15:0] obs;

  int n_chk = 0;
  int n_err = 0;
  int model_cnt = 0;

  localparam logic [15:0] TRP    = 16'h0001;
  localparam logic [15:0] BSY    = 16'h0002;
  localparam logic [15:0] MWE    = 16'h0004;
  localparam logic [15:0] MRQ    = 16'h0008;
  localparam logic [15:0] RW     = 16'h0010;
  localparam logic [15:0] IW     = 16'h0020;
  localparam logic [15:0] PW     = 16'h0040;
  localparam logic [15:0] PS_BR  = 16'h0080;
  localparam logic [15:0] PS_JAL = 16'h0100;
  localparam logic [15:0] WB_MEM = 16'h0200;
  localparam logic [15:0] WB_PC  = 16'h0400;
  localparam logic [15:0] WB_IMM = 16'h0600;
  localparam logic [15:0] BSEL   = 16'h0800;

  mc_ctrl_fsm #(
    .ALU_OP_W(4),
    .WAIT_MAX(15),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .br_taken (br_taken),
    .mem_ready(mem_ready),
    .alu_op   (alu_op),
    .alu_b_sel(alu_b_sel),
    .wb_sel   (wb_sel),
    .pc_src   (pc_src),
    .pc_write (pc_write),
    .ir_write (ir_write),
    .reg_write(reg_write),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .busy     (busy),
    .trap     (trap),
    .instr_cnt(instr_cnt)
  );

  assign obs = {alu_op, alu_b_sel, wb_sel, pc_src, pc_write, ir_write, reg_write,
                mem_req, mem_we, busy, trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs already driven; checks this cycle, then advances.
  task automatic cyc(input string tag, input logic [15:0] exp, input bit retire);
    #2;
    check_eq(tag, 32'(obs), 32'(exp));
    check_eq({tag, "_cnt"}, 32'(instr_cnt), 32'(model_cnt));
    @(posedge clk);
    #1;
    if (retire) model_cnt = (model_cnt + 1) % 16;
  endtask

  function automatic logic [6:0] opc_of(input int k);
    case (k)
      0:       return 7'b0110011;
      1:       return 7'b0010011;
      2:       return 7'b0000011;
      3:       return 7'b0100011;
      4:       return 7'b1100011;
      5:       return 7'b1101111;
      6:       return 7'b0110111;
      default: return 7'b1110011;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    for (int k = 0; k < 7; k++) if (opc_of(k) == o) return 1'b1;
    return 1'b0;
  endfunction

  // kind: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 jal, 6 lui, 7 illegal.
  // fw/mw: not-ready cycles in fetch / data memory; mw<0 means memory never answers.
  task automatic run_instr(input int kind, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [6:0] f7, input int fw, input int mw, input bit brt,
                           input bit en_nxt);
    logic [3:0]  aop;
    logic [15:0] mv;
    bit          st;
    int          nw;
    opcode   = opc;
    funct3   = f3;
    funct7   = f7;
    br_taken = brt;
    en       = en_nxt;
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0;
      cyc("fetch_wait", MRQ | BSY, 1'b0);
    end
    mem_ready = 1'b1;
    cyc("fetch", MRQ | IW | PW | BSY, 1'b0);
    mem_ready = 1'($urandom);
    cyc("decode", BSY, 1'b0);
    mem_ready = 1'($urandom);
    case (kind)
      0: begin
        aop = {f7[5], f3};
        cyc("exec_r", {aop, 12'h000} | BSY, 1'b0);
        cyc("wb_alu", RW | BSY, 1'b1);
      end
      1: begin
        aop = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
        cyc("exec_i", {aop, 12'h000} | BSEL | BSY, 1'b0);
        cyc("wb_alu", RW | BSY, 1'b1);
      end
      2, 3: begin
        st = (kind == 3);
        mv = MRQ | BSY | (st ? MWE : 16'h0000);
        cyc("mem_addr", BSEL | BSY, 1'b0);
        nw = (mw < 0) ? 16 : mw;
        for (int i = 0; i < nw; i++) begin
          mem_ready = 1'b0;
          cyc(st ? "mem_wr_wait" : "mem_rd_wait", mv, 1'b0);
        end
        if (mw < 0) begin
          for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom);
            cyc("timeout_trap", TRP, 1'b0);
          end
          return;
        end
        mem_ready = 1'b1;
        cyc(st ? "mem_wr" : "mem_rd", mv, st);
        if (!st) begin
          mem_ready = 1'($urandom);
          cyc("wb_mem", RW | WB_MEM | BSY, 1'b1);
        end
      end
      4: cyc("branch", 16'h8000 | PS_BR | (brt ? PW : 16'h0000) | BSY, 1'b1);
      5: cyc("jal", RW | WB_PC | PW | PS_JAL | BSY, 1'b1);
      6: cyc("lui", RW | WB_IMM | BSY, 1'b1);
      default: begin
        for (int i = 0; i < 3; i++) begin
          mem_ready = 1'($urandom);
          cyc("illegal_trap", TRP, 1'b0);
        end
        return;
      end
    endcase
    if (!en_nxt) begin
      cyc("idle_hold", 16'h0000, 1'b0);
      en = 1'b1;
      cyc("idle_go", 16'h0000, 1'b0);
    end
  endtask

  // Leaves the DUT in FETCH at posedge+1.
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    #1;
    cyc("idle", 16'h0000, 1'b0);
    en = 1'b1;
    cyc("idle_go", 16'h0000, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_out"}, 32'(obs), 32'h0);
    check_eq({tag, "_cnt"}, 32'(instr_cnt), 32'h0);
    model_cnt = 0;
    release_reset();
  endtask

  initial begin
    logic [6:0] ill;
    rst_n     = 1'b0;
    en        = 1'b0;
    opcode    = 7'h0;
    funct3    = 3'h0;
    funct7    = 7'h0;
    br_taken  = 1'b0;
    mem_ready = 1'b0;
    #12;
    check_eq("reset_out", 32'(obs), 32'h0);
    check_eq("reset_cnt", 32'(instr_cnt), 32'h0);
    release_reset();

    run_instr(0, opc_of(0), 3'b000, 7'b0000000, 0, 0, 1'b0, 1'b1);  // ADD
    run_instr(1, opc_of(1), 3'b101, 7'b0100000, 0, 0, 1'b0, 1'b1);  // SRAI
    run_instr(1, opc_of(1), 3'b000, 7'b0100000, 1, 0, 1'b0, 1'b1);  // ADDI, f7[5]=1
    run_instr(0, opc_of(0), 3'b000, 7'b0100000, 0, 0, 1'b0, 1'b1);  // SUB
    run_instr(2, opc_of(2), 3'b010, 7'b0000000, 0, 3, 1'b0, 1'b1);  // LW, 3 waits
    run_instr(2, opc_of(2), 3'b010, 7'b0000000, 0, 15, 1'b0, 1'b1); // ready at last chance
    run_instr(3, opc_of(3), 3'b010, 7'b0000000, 15, 0, 1'b0, 1'b1); // fetch at last chance
    run_instr(4, opc_of(4), 3'b000, 7'b0000000, 0, 0, 1'b0, 1'b1);  // BEQ not taken
    run_instr(4, opc_of(4), 3'b000, 7'b0000000, 0, 0, 1'b1, 1'b1);  // BEQ taken
    run_instr(5, opc_of(5), 3'b000, 7'b0000000, 0, 0, 1'b0, 1'b1);
    run_instr(6, opc_of(6), 3'b000, 7'b0000000, 0, 0, 1'b0, 1'b0);  // en dropped mid-instr

    for (int n = 0; n < 80; n++) begin
      int k;
      k = $urandom_range(0, 6);
      run_instr(k, opc_of(k), 3'($urandom), 7'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 4), 1'($urandom), $urandom_range(0, 5) != 0);
    end

    run_instr(3, opc_of(3), 3'b010, 7'b0000000, 0, -1, 1'b0, 1'b1);  // SW never ready
    do_reset("rst_after_timeout");

    run_instr(7, 7'b1110011, 3'b000, 7'b0000000, 0, 0, 1'b0, 1'b1);
    do_reset("rst_after_ecall");
    for (int n = 0; n < 3; n++) begin
      ill = 7'($urandom);
      while (is_legal(ill)) ill = 7'($urandom);
      run_instr(7, ill, 3'($urandom), 7'($urandom), 0, 0, 1'b0, 1'b1);
      do_reset("rst_after_illegal");
    end

    run_instr(0, opc_of(0), 3'b111, 7'b0000000, 0, 0, 1'b0, 1'b1);
    opcode    = opc_of(2);
    mem_ready = 1'b1;
    cyc("lw_fetch", MRQ | IW | PW | BSY, 1'b0);
    mem_ready = 1'b0;
    cyc("lw_decode", BSY, 1'b0);
    cyc("lw_mem_addr", BSEL | BSY, 1'b0);
    cyc("lw_mem_rd_wait", MRQ | BSY, 1'b0);
    cyc("lw_mem_rd_wait", MRQ | BSY, 1'b0);
    do_reset("rst_in_mem_rd");
    run_instr(5, opc_of(5), 3'b000, 7'b0000000, 0, 0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
